tim_sched: RTL and testbench

- Round-robin scheduler that shares one one-shot timer instance (trig/load/outpulse interface) among N requesters, e.g. several duty/animation channels that each need a timed interval.
- Arbitrates requests, loads and fires the shared timer, waits for expiry, and returns a per-requester done pulse.
- Includes a watchdog so a missing expiry pulse cannot hang the resource.

---
 rtl/tim_sched.sv | 142 ++++++++++++++
 tb/tb_tim_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tim_sched.sv
// Round-robin arbiter that shares one one-shot timer among N requesters.
// It loads and fires the timer, waits for expiry and returns a done pulse; a watchdog bounds the wait.
module tim_sched #(
    parameter int N       = 4,
    parameter int W       = 10,
    parameter int TIMEOUT = 2048
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_load,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic           timeout_err,
    output logic           tim_trig,
    output logic [W-1:0]   tim_load,
    input  logic           tim_pulse
);
    localparam int IDX_W = $clog2(N);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     done_q, done_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             tim_trig_q, tim_trig_d;
    logic [W-1:0]     tim_load_q, tim_load_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [W-1:0]     sel_load;
    int               cand;

    // Search starts just after the last served requester, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(rr_ptr_q) + k) % N;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        sel_load = req_load[int'(sel_idx)*W +: W];
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rr_ptr_d      = rr_ptr_q;
        wd_d          = wd_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        timeout_err_d = 1'b0;
        tim_trig_d    = 1'b0;
        tim_load_d    = tim_load_q;
        case (state_q)
            S_IDLE: begin
                gnt_d      = '0;
                tim_load_d = '0;
                if (sel_found) begin
                    idx_d      = sel_idx;
                    gnt_d      = N'(1) << sel_idx;
                    tim_load_d = sel_load;
                    if (sel_load == '0) begin
                        state_d = S_DONE;
                        done_d  = N'(1) << sel_idx;
                    end else begin
                        state_d    = S_FIRE;
                        tim_trig_d = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A real expiry wins over a watchdog expiry in the same cycle.
                if (tim_pulse) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d       = S_DONE;
                    done_d        = gnt_q;
                    timeout_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rr_ptr_d   = idx_q;
                gnt_d      = '0;
                tim_load_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            rr_ptr_q      <= IDX_W'(N - 1);
            wd_q          <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tim_trig_q    <= 1'b0;
            tim_load_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_q          <= wd_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tim_trig_q    <= tim_trig_d;
            tim_load_q    <= tim_load_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign tim_trig    = tim_trig_q;
    assign tim_load    = tim_load_q;
endmodule

// File: tb/tb_tim_sched.sv
// Bench for tim_sched: directed scenarios plus randomized services checked
// against a transaction-level round-robin and timing model.
module tb_tim_sched;
    localparam int N       = 4;
    localparam int W       = 10;
    localparam int TIMEOUT = 2048;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_load;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic           timeout_err;
    logic           tim_trig;
    logic [W-1:0]   tim_load;
    logic           tim_pulse;

    int             checks = 0;
    int             errors = 0;
    int             last;
    logic [N*W-1:0] lv;
    logic [N-1:0]   rv;
    logic [N-1:0]   acc;

    always #5 clk = ~clk;

    tim_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_load(req_load),
        .gnt(gnt), .done(done), .busy(busy), .timeout_err(timeout_err),
        .tim_trig(tim_trig), .tim_load(tim_load), .tim_pulse(tim_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return 0;
    endfunction

    function automatic logic [N*W-1:0] mk(input int l0, input int l1, input int l2, input int l3);
        logic [N*W-1:0] v;
        v = {W'(l3), W'(l2), W'(l1), W'(l0)};
        return v;
    endfunction

    // One complete service, entered and left at the negedge of an IDLE cycle.
    // d: timer pulse delay after trig (<0: use the load, 0: timer silent).
    task automatic serve(input logic [N-1:0] r, input logic [N*W-1:0] loads,
                         input int d, input bit hold, input bit fire_pulse);
        int         idx;
        int         dd;
        int         j;
        int         exp_j;
        bit         exp_err;
        logic [W-1:0] ld;
        logic [N-1:0] oh;
        idx = pick(r, last);
        ld  = loads[idx*W +: W];
        oh  = N'(1) << idx;
        dd  = (d < 0) ? int'(ld) : d;
        req = r;
        req_load = loads;
        step();
        chk("gnt", 32'(gnt), 32'(oh));
        chk("busy", 32'(busy), 1);
        if (!hold) req = '0;
        req_load = {$urandom, $urandom};
        if (ld == '0) begin
            chk("zl_trig", 32'(tim_trig), 0);
            chk("zl_done", 32'(done), 32'(oh));
            chk("zl_terr", 32'(timeout_err), 0);
        end else begin
            chk("trig", 32'(tim_trig), 1);
            chk("load", 32'(tim_load), 32'(ld));
            chk("done_early", 32'(done), 0);
            exp_err = !(dd >= 1 && dd <= TIMEOUT);
            exp_j   = exp_err ? TIMEOUT + 1 : dd + 1;
            tim_pulse = fire_pulse;
            j = 0;
            while (done == '0 && j < TIMEOUT + 16) begin
                step();
                j++;
                tim_pulse = (j == dd);
                if (j == 1) chk("trig_off", 32'(tim_trig), 0);
            end
            tim_pulse = 1'b0;
            chk("done_cycle", 32'(j), 32'(exp_j));
            chk("done", 32'(done), 32'(oh));
            chk("terr", 32'(timeout_err), 32'(exp_err));
            chk("gnt_done", 32'(gnt), 32'(oh));
            chk("load_hold", 32'(tim_load), 32'(ld));
        end
        last = idx;
        step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_done", 32'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req_load = '0;
        tim_pulse = 1'b0;
        last = N - 1;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_trig", 32'(tim_trig), 0);
        chk("rst_load", 32'(tim_load), 0);
        rst = 1'b0;

        // Stale expiry pulse while idle.
        tim_pulse = 1'b1;
        step();
        tim_pulse = 1'b0;
        chk("stale_busy", 32'(busy), 0);
        step();
        chk("stale_busy2", 32'(busy), 0);
        chk("stale_done", 32'(done), 0);

        serve(4'b0001, mk(70, 0, 0, 0), -1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++)
            serve(4'b1111, mk(5, 5, 5, 5), -1, 1'b1, 1'b0);
        req = '0;

        serve(4'b0010, mk(9, 0, 9, 9), -1, 1'b0, 1'b0);

        serve(4'b0100, mk(0, 0, 100, 0), 0, 1'b0, 1'b0);
        serve(4'b0100, mk(0, 0, 100, 0), TIMEOUT, 1'b0, 1'b1);

        // Reset while requester 3 is waiting on the timer.
        req = 4'b1000;
        req_load = mk(0, 0, 0, 50);
        step();
        chk("rw_gnt", 32'(gnt), 32'(4'b1000));
        req = '0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_gnt0", 32'(gnt), 0);
        chk("rw_done0", 32'(done), 0);
        chk("rw_busy0", 32'(busy), 0);
        chk("rw_trig0", 32'(tim_trig), 0);
        chk("rw_load0", 32'(tim_load), 0);
        chk("rw_terr0", 32'(timeout_err), 0);
        last = N - 1;
        acc = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            acc = acc | done;
        end
        chk("rw_no_done", 32'(acc), 0);
        serve(4'b1001, mk(7, 0, 0, 7), -1, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                lv[i*W +: W] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 30));
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                tim_pulse = 1'b1;
                step();
                tim_pulse = 1'b0;
                chk("rnd_stale", 32'(busy), 0);
            end
            serve(rv, lv, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
